// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI blanking-period scheduler: phase lengths,
// CTL preamble codes, island owner encoding, state enums and phase helpers.
package hdmi_pkg;

  localparam int D_PRE_LEN   = 8;
  localparam int D_GB_LEN    = 2;
  localparam int D_PKT_LEN   = 32;
  localparam int D_TRAIL_LEN = 2;
  localparam int V_PRE_LEN   = 8;
  localparam int V_GB_LEN    = 2;
  localparam int ISLAND_LEN  = D_PRE_LEN + D_GB_LEN + D_PKT_LEN + D_TRAIL_LEN;

  localparam logic [3:0] CTL_DATA_PRE = 4'b0101;
  localparam logic [3:0] CTL_VID_PRE  = 4'b0001;

  localparam logic [1:0] GRANT_NULL = 2'd0;
  localparam logic [1:0] GRANT_AUD  = 2'd1;
  localparam logic [1:0] GRANT_AVI  = 2'd2;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_PRE,
    DS_GB_LEAD,
    DS_PKT,
    DS_GB_TRAIL
  } data_state_e;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_PRE,
    VS_GB
  } vid_state_e;

  // Last counter value of each island phase (phase length - 1).
  function automatic logic [4:0] phase_last(input data_state_e s);
    case (s)
      DS_PRE:      return 5'(D_PRE_LEN - 1);
      DS_GB_LEAD:  return 5'(D_GB_LEN - 1);
      DS_PKT:      return 5'(D_PKT_LEN - 1);
      DS_GB_TRAIL: return 5'(D_TRAIL_LEN - 1);
      default:     return 5'd0;
    endcase
  endfunction

  function automatic data_state_e phase_next(input data_state_e s);
    case (s)
      DS_PRE:     return DS_GB_LEAD;
      DS_GB_LEAD: return DS_PKT;
      DS_PKT:     return DS_GB_TRAIL;
      default:    return DS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_pkt_arbiter.sv
// Fixed-priority packet source selection at the island trigger.
// Ports:
//   trigger  in   island trigger (counter_x match while the island FSM is idle)
//   avi_req  in   AVI InfoFrame request level (highest priority)
//   aud_req  in   audio packet request level
//   fire     out  an island starts this cycle
//   grant    out  owner for the island about to start (null/audio/AVI)
//   avi_ack  out  AVI source wins this trigger
//   aud_ack  out  audio source wins this trigger
module hdmi_pkt_arbiter
  import hdmi_pkg::*;
#(
  parameter int ALWAYS_ISLAND = 1
) (
  input  logic       trigger,
  input  logic       avi_req,
  input  logic       aud_req,
  output logic       fire,
  output logic [1:0] grant,
  output logic       avi_ack,
  output logic       aud_ack
);

  always_comb begin
    grant = GRANT_NULL;
    if (avi_req) begin
      grant = GRANT_AVI;
    end else if (aud_req) begin
      grant = GRANT_AUD;
    end
    // Without a pending request the island is only sent as a null packet
    // when ALWAYS_ISLAND is set.
    fire    = trigger && (avi_req || aud_req || (ALWAYS_ISLAND != 0));
    avi_ack = fire && avi_req;
    aud_ack = fire && !avi_req && aud_req;
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI horizontal-blanking scheduler: data-island sequencing (preamble, guard
// bands, 32-word packet) and video preamble/guard band ahead of active lines.
// Ports:
//   pixclk, reset           pixel clock, asynchronous active-high reset
//   counter_x, counter_y    current pixel column / line
//   avi_req, aud_req        packet source request levels
//   avi_ack, aud_ack        one-cycle grant pulses
//   grant_sel               island owner (0 null, 1 audio, 2 AVI)
//   ctl                     CTL3..CTL0 during preambles
//   terc_data, data_gb      TERC4 period / island guard band
//   video_gb                video guard band
//   pkt_valid, pkt_first, pkt_word   packet word strobes and index
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int FULL_WIDTH     = 768,
  parameter int FULL_HEIGHT    = 528,
  parameter int DATA_START     = 660,
  parameter int ALWAYS_ISLAND  = 1
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       avi_req,
  input  logic       aud_req,
  output logic       avi_ack,
  output logic       aud_ack,
  output logic [1:0] grant_sel,
  output logic [3:0] ctl,
  output logic       terc_data,
  output logic       data_gb,
  output logic       video_gb,
  output logic       pkt_valid,
  output logic       pkt_first,
  output logic [4:0] pkt_word
);

  if ((DATA_START < DISPLAY_WIDTH + 12) ||
      (DATA_START + ISLAND_LEN > FULL_WIDTH - 10)) begin : g_param_check
    $error("hdmi_island_scheduler: island overlaps active video or video preamble");
  end

  localparam logic [9:0] X_DATA  = 10'(DATA_START);
  localparam logic [9:0] X_VIDEO = 10'(FULL_WIDTH - 10);
  localparam logic [9:0] Y_LAST  = 10'(FULL_HEIGHT - 1);
  localparam logic [9:0] Y_ACT   = 10'(DISPLAY_HEIGHT);

  data_state_e ds_q, ds_d;
  vid_state_e  vs_q, vs_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [2:0]  vcnt_q, vcnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        avi_ack_q, avi_ack_d, aud_ack_q, aud_ack_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        terc_q, terc_d, dgb_q, dgb_d, vgb_q, vgb_d;
  logic        pv_q, pv_d, pf_q, pf_d;
  logic [4:0]  pw_q, pw_d;

  logic       arb_fire, arb_avi_ack, arb_aud_ack;
  logic [1:0] arb_grant;
  logic [9:0] next_y;
  logic       vid_trig;

  hdmi_pkt_arbiter #(
    .ALWAYS_ISLAND(ALWAYS_ISLAND)
  ) u_arb (
    .trigger (ds_q == DS_IDLE && counter_x == X_DATA),
    .avi_req (avi_req),
    .aud_req (aud_req),
    .fire    (arb_fire),
    .grant   (arb_grant),
    .avi_ack (arb_avi_ack),
    .aud_ack (arb_aud_ack)
  );

  // Video preamble precedes a line only if the following line is active.
  always_comb begin
    next_y   = (counter_y == Y_LAST) ? 10'd0 : counter_y + 10'd1;
    vid_trig = (counter_x == X_VIDEO) && (next_y < Y_ACT);
  end

  // Island sequencer: fixed phase lengths, immune to counter_x jumps.
  always_comb begin
    ds_d      = ds_q;
    dcnt_d    = dcnt_q;
    grant_d   = grant_q;
    avi_ack_d = 1'b0;
    aud_ack_d = 1'b0;
    if (ds_q == DS_IDLE) begin
      if (arb_fire) begin
        ds_d      = DS_PRE;
        dcnt_d    = 5'd0;
        grant_d   = arb_grant;
        avi_ack_d = arb_avi_ack;
        aud_ack_d = arb_aud_ack;
      end
    end else if (dcnt_q == phase_last(ds_q)) begin
      ds_d   = phase_next(ds_q);
      dcnt_d = 5'd0;
    end else begin
      dcnt_d = dcnt_q + 5'd1;
    end
  end

  always_comb begin
    vs_d   = vs_q;
    vcnt_d = vcnt_q;
    case (vs_q)
      VS_IDLE: if (vid_trig) begin
        vs_d   = VS_PRE;
        vcnt_d = 3'd0;
      end
      VS_PRE: if (vcnt_q == 3'(V_PRE_LEN - 1)) begin
        vs_d   = VS_GB;
        vcnt_d = 3'd0;
      end else begin
        vcnt_d = vcnt_q + 3'd1;
      end
      VS_GB: if (vcnt_q == 3'(V_GB_LEN - 1)) begin
        vs_d   = VS_IDLE;
        vcnt_d = 3'd0;
      end else begin
        vcnt_d = vcnt_q + 3'd1;
      end
      default: begin
        vs_d   = VS_IDLE;
        vcnt_d = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // one pixclk after the trigger column is sampled.
  always_comb begin
    ctl_d  = 4'b0000;
    terc_d = 1'b0;
    dgb_d  = 1'b0;
    vgb_d  = 1'b0;
    pv_d   = 1'b0;
    pf_d   = 1'b0;
    pw_d   = 5'd0;
    case (ds_d)
      DS_PRE: ctl_d = CTL_DATA_PRE;
      DS_GB_LEAD, DS_GB_TRAIL: begin
        terc_d = 1'b1;
        dgb_d  = 1'b1;
      end
      DS_PKT: begin
        terc_d = 1'b1;
        pv_d   = 1'b1;
        pf_d   = (dcnt_d == 5'd0);
        pw_d   = dcnt_d;
      end
      default: ;
    endcase
    if (vs_d == VS_PRE) ctl_d = CTL_VID_PRE;
    if (vs_d == VS_GB) vgb_d = 1'b1;
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      ds_q      <= DS_IDLE;
      vs_q      <= VS_IDLE;
      dcnt_q    <= 5'd0;
      vcnt_q    <= 3'd0;
      grant_q   <= GRANT_NULL;
      avi_ack_q <= 1'b0;
      aud_ack_q <= 1'b0;
      ctl_q     <= 4'b0000;
      terc_q    <= 1'b0;
      dgb_q     <= 1'b0;
      vgb_q     <= 1'b0;
      pv_q      <= 1'b0;
      pf_q      <= 1'b0;
      pw_q      <= 5'd0;
    end else begin
      ds_q      <= ds_d;
      vs_q      <= vs_d;
      dcnt_q    <= dcnt_d;
      vcnt_q    <= vcnt_d;
      grant_q   <= grant_d;
      avi_ack_q <= avi_ack_d;
      aud_ack_q <= aud_ack_d;
      ctl_q     <= ctl_d;
      terc_q    <= terc_d;
      dgb_q     <= dgb_d;
      vgb_q     <= vgb_d;
      pv_q      <= pv_d;
      pf_q      <= pf_d;
      pw_q      <= pw_d;
    end
  end

  assign avi_ack   = avi_ack_q;
  assign aud_ack   = aud_ack_q;
  assign grant_sel = grant_q;
  assign ctl       = ctl_q;
  assign terc_data = terc_q;
  assign data_gb   = dgb_q;
  assign video_gb  = vgb_q;
  assign pkt_valid = pv_q;
  assign pkt_first = pf_q;
  assign pkt_word  = pw_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Scoreboard bench for hdmi_island_scheduler: two instances (ALWAYS_ISLAND 1
// and 0) share stimulus; per-cycle expected outputs are queued by the
// stimulus and checked by a negedge monitor.
module tb_hdmi_island_scheduler;

  typedef struct packed {
    logic [3:0] ctl;
    logic       terc;
    logic       dgb;
    logic       vgb;
    logic       pv;
    logic       pf;
    logic [4:0] pw;
    logic [1:0] gs;
    logic       aa;
    logic       ua;
  } exp_t;

  logic       pixclk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] counter_x = 10'd0;
  logic [9:0] counter_y = 10'd0;
  logic       avi_req = 1'b0;
  logic       aud_req = 1'b0;

  logic       a_avi_ack, a_aud_ack, a_terc, a_dgb, a_vgb, a_pv, a_pf;
  logic [1:0] a_gs;
  logic [3:0] a_ctl;
  logic [4:0] a_pw;
  logic       b_avi_ack, b_aud_ack, b_terc, b_dgb, b_vgb, b_pv, b_pf;
  logic [1:0] b_gs;
  logic [3:0] b_ctl;
  logic [4:0] b_pw;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] g_a = 2'd0;
  logic [1:0] g_b = 2'd0;
  bit   vcarry = 1'b0;

  always #5 pixclk = ~pixclk;

  hdmi_island_scheduler #(.ALWAYS_ISLAND(1)) dut_a (
    .pixclk(pixclk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .avi_req(avi_req), .aud_req(aud_req), .avi_ack(a_avi_ack), .aud_ack(a_aud_ack),
    .grant_sel(a_gs), .ctl(a_ctl), .terc_data(a_terc), .data_gb(a_dgb),
    .video_gb(a_vgb), .pkt_valid(a_pv), .pkt_first(a_pf), .pkt_word(a_pw)
  );

  hdmi_island_scheduler #(.ALWAYS_ISLAND(0)) dut_b (
    .pixclk(pixclk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .avi_req(avi_req), .aud_req(aud_req), .avi_ack(b_avi_ack), .aud_ack(b_aud_ack),
    .grant_sel(b_gs), .ctl(b_ctl), .terc_data(b_terc), .data_gb(b_dgb),
    .video_gb(b_vgb), .pkt_valid(b_pv), .pkt_first(b_pf), .pkt_word(b_pw)
  );

  exp_t act_a, act_b;
  assign act_a = {a_ctl, a_terc, a_dgb, a_vgb, a_pv, a_pf, a_pw, a_gs, a_avi_ack, a_aud_ack};
  assign act_b = {b_ctl, b_terc, b_dgb, b_vgb, b_pv, b_pf, b_pw, b_gs, b_avi_ack, b_aud_ack};

  // Expected outputs while counter_x shows column x (trigger at 660).
  function automatic exp_t model(input int x, input bit isl, input logic [1:0] w,
                                 input logic [1:0] gprev, input bit vnext,
                                 input bit vcar, input int rst_x);
    exp_t e;
    bit   killed;
    bit   on;
    e      = '0;
    killed = (rst_x >= 0) && (x >= rst_x);
    on     = isl && !killed;
    if (on && x >= 661 && x <= 668) e.ctl = 4'b0101;
    if (on && ((x >= 669 && x <= 670) || (x >= 703 && x <= 704))) begin
      e.terc = 1'b1;
      e.dgb  = 1'b1;
    end
    if (on && x >= 671 && x <= 702) begin
      e.terc = 1'b1;
      e.pv   = 1'b1;
      e.pw   = 5'(x - 671);
      e.pf   = (x == 671);
    end
    if (vnext && x >= 759 && x <= 766) e.ctl = 4'b0001;
    if ((vnext && x == 767) || (vcar && x == 0)) e.vgb = 1'b1;
    e.gs = (isl && x >= 661) ? w : gprev;
    if (killed) e.gs = 2'd0;
    e.aa = isl && (x == 661) && (w == 2'd2);
    e.ua = isl && (x == 661) && (w == 2'd1);
    return e;
  endfunction

  // One full line at row y; request levels held from x=0 (aud may rise at
  // aud_rise_x instead); optional async reset pulse starting at rst_x.
  task automatic run_line(input int y, input bit avi, input bit aud,
                          input int aud_rise_x, input int rst_x);
    bit         vnext;
    bit         isl_a, isl_b;
    logic [1:0] w;
    vnext   = (((y + 1) % 528) < 480);
    w       = avi ? 2'd2 : (aud ? 2'd1 : 2'd0);
    isl_a   = 1'b1;
    isl_b   = avi | aud;
    avi_req = avi;
    aud_req = aud;
    for (int x = 0; x < 768; x++) begin
      @(posedge pixclk);
      #1;
      counter_x = 10'(x);
      counter_y = 10'(y);
      if (aud_rise_x >= 0 && x == aud_rise_x) aud_req = 1'b1;
      qa.push_back(model(x, isl_a, w, g_a, vnext, vcarry, rst_x));
      qb.push_back(model(x, isl_b, w, g_b, vnext, vcarry, rst_x));
      if (rst_x >= 0 && x == rst_x) begin
        #1 reset = 1'b1;
      end
      if (rst_x >= 0 && x == rst_x + 2) begin
        #1 reset = 1'b0;
      end
    end
    if (rst_x >= 0) begin
      g_a = 2'd0;
      g_b = 2'd0;
    end else begin
      if (isl_a) g_a = w;
      if (isl_b) g_b = w;
    end
    vcarry = vnext;
  endtask

  always @(negedge pixclk) begin
    exp_t ea, eb;
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_tests++;
      if (act_a !== ea) begin
        n_fail++;
        $display("FAIL dut_a_outputs x=%0d y=%0d got=%h want=%h", counter_x, counter_y, act_a, ea);
      end
      n_tests++;
      if (act_b !== eb) begin
        n_fail++;
        $display("FAIL dut_b_outputs x=%0d y=%0d got=%h want=%h", counter_x, counter_y, act_b, eb);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge pixclk);
    @(negedge pixclk);
    n_tests++;
    if (act_a !== '0) begin
      n_fail++;
      $display("FAIL reset_state_a got=%h want=0", act_a);
    end
    n_tests++;
    if (act_b !== '0) begin
      n_fail++;
      $display("FAIL reset_state_b got=%h want=0", act_b);
    end
    @(posedge pixclk);
    #2 reset = 1'b0;

    run_line(100, 1'b0, 1'b0, -1, -1);   // null island (A only)
    run_line(101, 1'b1, 1'b1, -1, -1);   // AVI wins over audio
    run_line(102, 1'b0, 1'b1, -1, -1);   // audio served next line
    run_line(479, 1'b0, 1'b0, -1, -1);   // next line blank: no video preamble
    run_line(527, 1'b0, 1'b0, -1, -1);   // wrap to line 0: video preamble
    run_line(0,   1'b0, 1'b0, -1, -1);   // guard band at x=0
    run_line(200, 1'b0, 1'b0, 676, -1);  // audio rises at pkt_word 5
    run_line(201, 1'b0, 1'b1, -1, -1);   // audio granted on following line
    run_line(202, 1'b1, 1'b0, -1, 686);  // reset at pkt_word 15
    run_line(203, 1'b0, 1'b0, -1, -1);   // islands resume after reset

    @(negedge pixclk);
    @(negedge pixclk);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
